// File: rtl/pll_led_pwm.sv
// pll_led_pwm: multi-channel LED driver (OFF/ON/PWM/BLINK) clocked by a shared prescaler tick.
// Define PLL_LED_PWM_SYNC_EN to add a sync input that realigns all channel counters.
module pll_led_pwm #(
  parameter int CHANNELS       = 7,
  parameter int CNT_WIDTH      = 16,
  parameter int PRESCALE       = 1000,
  parameter int DEFAULT_PERIOD = 499,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 RST,
`ifdef PLL_LED_PWM_SYNC_EN
  input  logic                 sync,
`endif
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  output logic                 cfg_err,
  output logic [CHANNELS-1:0]  wrap,
  output logic [CHANNELS-1:0]  led
);
  typedef enum logic [1:0] {M_OFF, M_ON, M_PWM, M_BLINK} mode_e;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_WIDTH-1:0] DEF_P = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] DEF_D = CNT_WIDTH'(DEFAULT_PERIOD >> 1);
  logic sync_i;
`ifdef PLL_LED_PWM_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif
  logic [PW-1:0] pre_q, pre_d;
  logic tick, cfg_ok;
  logic cfg_err_q, cfg_err_d;
  logic [CHANNELS-1:0] wrap_q, wrap_d, led_q, led_d, sel, wev;
  mode_e mode_q [CHANNELS];
  mode_e mode_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CNT_WIDTH-1:0] period_q [CHANNELS];
  logic [CNT_WIDTH-1:0] period_d [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_q [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_d [CHANNELS];
  logic [CNT_WIDTH-1:0] pper_q [CHANNELS];
  logic [CNT_WIDTH-1:0] pper_d [CHANNELS];
  logic [CNT_WIDTH-1:0] pduty_q [CHANNELS];
  logic [CNT_WIDTH-1:0] pduty_d [CHANNELS];
  assign tick    = pre_q == PW'(PRESCALE - 1);
  assign cfg_ok  = cfg_we && (32'(cfg_ch) < 32'(CHANNELS));
  assign cfg_err = cfg_err_q;
  assign wrap    = wrap_q;
  assign led     = led_q;
  // Pending values include this cycle's write so a coincident wrap picks them up.
  always_comb begin
    pre_d     = (tick || sync_i) ? '0 : pre_q + 1'b1;
    cfg_err_d = cfg_we && !cfg_ok;
    sel       = '0;
    wev       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel[i]      = cfg_ok && (32'(cfg_ch) == i);
      mode_d[i]   = sel[i] ? mode_e'(cfg_mode) : mode_q[i];
      pper_d[i]   = sel[i] ? cfg_period : pper_q[i];
      pduty_d[i]  = sel[i] ? cfg_duty : pduty_q[i];
      wev[i]      = tick && !sync_i && (cnt_q[i] == period_q[i]);
      cnt_d[i]    = (wev[i] || sync_i) ? '0 : tick ? cnt_q[i] + 1'b1 : cnt_q[i];
      period_d[i] = (wev[i] || sync_i) ? pper_d[i] : period_q[i];
      duty_d[i]   = (wev[i] || sync_i) ? pduty_d[i] : duty_q[i];
      wrap_d[i]   = wev[i];
      led_d[i]    = (mode_d[i] == M_OFF) ? 1'b0 :
                    (mode_d[i] == M_ON)  ? 1'b1 :
                    (mode_d[i] == M_PWM) ? (cnt_q[i] < duty_q[i]) :
                    sync_i ? 1'b0 : (led_q[i] ^ wev[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      pre_q     <= '0;
      cfg_err_q <= 1'b0;
      wrap_q    <= '0;
      led_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= M_BLINK;
        cnt_q[i]    <= '0;
        period_q[i] <= DEF_P;
        pper_q[i]   <= DEF_P;
        duty_q[i]   <= DEF_D;
        pduty_q[i]  <= DEF_D;
      end
    end else begin
      pre_q     <= pre_d;
      cfg_err_q <= cfg_err_d;
      wrap_q    <= wrap_d;
      led_q     <= led_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pper_q    <= pper_d;
      duty_q    <= duty_d;
      pduty_q   <= pduty_d;
    end
  end
endmodule
